// File: rtl/cond_unit.sv
// ---------------------------------------------------------------------------
// cond_unit -- conditional-execution unit for the CPU write-back path.
//
// Gates NUM_WE decoder write enables with a selectable condition evaluated on
// operand `a` or on a registered {V,C,N,Z} flags word. After a taken
// conditional write it opens a flush window of FLUSH_CYCLES cycles during
// which all writes and flag updates are suppressed.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   instr_valid  current instruction is valid
//   in_we        raw write enables from the decoder
//   cond_en      instruction is conditional
//   cond_sel     condition code select (0..7)
//   a            operand under test, also source of N/Z
//   flags_we     capture flags this cycle
//   alu_carry    ALU carry out  (C)
//   alu_ovf      ALU signed overflow (V)
//   out_we       gated write enables (combinational)
//   taken        condition passed on a valid conditional instruction
//   flush        flush window active
//   flags        registered {V,C,N,Z}
// ---------------------------------------------------------------------------
module cond_unit #(
    parameter int WIDTH        = 16,
    parameter int NUM_WE       = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [NUM_WE-1:0] in_we,
    input  logic              cond_en,
    input  logic [2:0]        cond_sel,
    input  logic [WIDTH-1:0]  a,
    input  logic              flags_we,
    input  logic              alu_carry,
    input  logic              alu_ovf,
    output logic [NUM_WE-1:0] out_we,
    output logic              taken,
    output logic              flush,
    output logic [3:0]        flags
);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Counter holds "remaining cycles after this one", so it loads N-1.
    localparam logic [3:0] FLUSH_LOAD =
        (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

    state_t     state;
    logic [3:0] flush_cnt;
    logic       flushing;
    logic       good;
    logic       a_zero;
    logic       a_neg;

    assign a_zero   = (a == '0);
    assign a_neg    = a[WIDTH-1];
    assign flushing = (state == FLUSH);
    assign flush    = flushing;

    // flags layout: [3]=V [2]=C [1]=N [0]=Z
    always_comb begin
        good = 1'b0;
        case (cond_sel)
            3'd0: good = ~a_zero;
            3'd1: good = a_zero;
            3'd2: good = a_neg;
            3'd3: good = ~a_neg;
            3'd4: good = flags[2];
            3'd5: good = ~flags[2];
            3'd6: good = flags[3];
            3'd7: good = flags[0];
            default: good = 1'b0;
        endcase
    end

    always_comb begin
        out_we = in_we & {NUM_WE{~flushing & (~cond_en | good)}};
    end

    assign taken = instr_valid & cond_en & good & ~flushing & (|in_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else if (flags_we && instr_valid && !flushing) begin
            flags <= {alu_ovf, alu_carry, a_neg, a_zero};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (taken && (FLUSH_CYCLES > 0)) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_LOAD;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    flush_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
module tb_cond_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        instr_valid;
    logic [1:0]  in_we;
    logic        cond_en;
    logic [2:0]  cond_sel;
    logic [15:0] a;
    logic        flags_we;
    logic        alu_carry;
    logic        alu_ovf;

    logic [1:0]  ow  [4];
    logic        tk  [4];
    logic        fl  [4];
    logic [3:0]  fg  [4];

    int checks   = 0;
    int failures = 0;

    // Instance k: 0 -> no flush, 1 -> 2-cycle flush, 2 -> 3-cycle flush,
    // 3 -> WIDTH=1 with 1-cycle flush.
    int         flush_len [4];
    int         flush_left[4];
    logic [3:0] mflags    [4];

    cond_unit #(.WIDTH(16), .NUM_WE(2), .FLUSH_CYCLES(0)) u_f0 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .in_we(in_we),
        .cond_en(cond_en), .cond_sel(cond_sel), .a(a), .flags_we(flags_we),
        .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .out_we(ow[0]), .taken(tk[0]), .flush(fl[0]), .flags(fg[0]));

    cond_unit #(.WIDTH(16), .NUM_WE(2), .FLUSH_CYCLES(2)) u_f2 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .in_we(in_we),
        .cond_en(cond_en), .cond_sel(cond_sel), .a(a), .flags_we(flags_we),
        .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .out_we(ow[1]), .taken(tk[1]), .flush(fl[1]), .flags(fg[1]));

    cond_unit #(.WIDTH(16), .NUM_WE(2), .FLUSH_CYCLES(3)) u_f3 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .in_we(in_we),
        .cond_en(cond_en), .cond_sel(cond_sel), .a(a), .flags_we(flags_we),
        .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .out_we(ow[2]), .taken(tk[2]), .flush(fl[2]), .flags(fg[2]));

    cond_unit #(.WIDTH(1), .NUM_WE(2), .FLUSH_CYCLES(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .in_we(in_we),
        .cond_en(cond_en), .cond_sel(cond_sel), .a(a[0:0]), .flags_we(flags_we),
        .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .out_we(ow[3]), .taken(tk[3]), .flush(fl[3]), .flags(fg[3]));

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic op_zero(input int k);
        return (k == 3) ? (a[0] == 1'b0) : (a == 16'd0);
    endfunction

    function automatic logic op_neg(input int k);
        return (k == 3) ? a[0] : a[15];
    endfunction

    function automatic logic cond_ok(input int k);
        logic [3:0] f;
        f = mflags[k];
        case (cond_sel)
            3'd0: return !op_zero(k);
            3'd1: return op_zero(k);
            3'd2: return op_neg(k);
            3'd3: return !op_neg(k);
            3'd4: return f[2];
            3'd5: return !f[2];
            3'd6: return f[3];
            default: return f[0];
        endcase
    endfunction

    function automatic logic exp_taken(input int k);
        return instr_valid && cond_en && cond_ok(k) && (flush_left[k] == 0) && (in_we != 2'b00);
    endfunction

    function automatic logic [1:0] exp_we(input int k);
        if (flush_left[k] > 0) return 2'b00;
        if (cond_en && !cond_ok(k)) return 2'b00;
        return in_we;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            flush_left[k] = 0;
            mflags[k]     = 4'b0000;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("out_we[%0d]", k), {2'b00, ow[k]}, {2'b00, exp_we(k)});
            check($sformatf("taken[%0d]", k),  {3'b000, tk[k]}, {3'b000, exp_taken(k)});
            check($sformatf("flush[%0d]", k),  {3'b000, fl[k]}, {3'b000, flush_left[k] > 0});
            check($sformatf("flags[%0d]", k),  fg[k], mflags[k]);
        end
    endtask

    task automatic drive(input logic iv, input logic [1:0] we, input logic ce,
                         input logic [2:0] sel, input logic [15:0] av,
                         input logic fwe, input logic c, input logic v);
        instr_valid = iv; in_we = we; cond_en = ce; cond_sel = sel;
        a = av; flags_we = fwe; alu_carry = c; alu_ovf = v;
        #1;
    endtask

    // Checks the current cycle, then advances one clock and the model with it.
    task automatic step();
        int         nleft[4];
        logic [3:0] nflags[4];
        check_all();
        for (int k = 0; k < 4; k++) begin
            nleft[k]  = flush_left[k];
            nflags[k] = mflags[k];
            if (instr_valid && flags_we && flush_left[k] == 0)
                nflags[k] = {alu_ovf, alu_carry, op_neg(k), op_zero(k)};
            if (flush_left[k] > 0)
                nleft[k] = flush_left[k] - 1;
            else if (exp_taken(k))
                nleft[k] = flush_len[k];
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++) begin
                flush_left[k] = nleft[k];
                mflags[k]     = nflags[k];
            end
        end
        @(negedge clk);
    endtask

    initial begin
        flush_len[0] = 0; flush_len[1] = 2; flush_len[2] = 3; flush_len[3] = 1;
        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        // Reset state, then out_we still follows the combinational rule.
        #1;
        check("rst_flush", {3'b000, fl[2]}, 4'h0);
        check("rst_flags", fg[0], 4'h0);
        step();
        drive(1'b0, 2'b11, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b1);
        check("rst_out_we", {2'b00, ow[1]}, 4'h3);
        step();
        rst_n = 1'b1;

        // Legacy equivalence on the no-flush instance.
        drive(1'b1, 2'b11, 1'b1, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("legacy_sel0_zero_we", {2'b00, ow[0]}, 4'h0);
        check("legacy_sel0_zero_tk", {3'b000, tk[0]}, 4'h0);
        step();
        drive(1'b1, 2'b11, 1'b1, 3'd0, 16'h0040, 1'b0, 1'b0, 1'b0);
        check("legacy_sel0_nz_we", {2'b00, ow[0]}, 4'h3);
        check("legacy_sel0_nz_tk", {3'b000, tk[0]}, 4'h1);
        step();
        drive(1'b1, 2'b11, 1'b1, 3'd1, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("legacy_sel1_zero_we", {2'b00, ow[0]}, 4'h3);
        step();
        drive(1'b1, 2'b11, 1'b1, 3'd1, 16'h0040, 1'b0, 1'b0, 1'b0);
        check("legacy_sel1_nz_tk", {3'b000, tk[0]}, 4'h0);
        step();
        drive(1'b1, 2'b11, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("uncond_we", {2'b00, ow[0]}, 4'h3);
        check("uncond_tk", {3'b000, tk[0]}, 4'h0);
        step();

        // Sign codes.
        drive(1'b1, 2'b11, 1'b1, 3'd2, 16'h8000, 1'b0, 1'b0, 1'b0);
        check("neg_8000", {2'b00, ow[0]}, 4'h3);
        step();
        drive(1'b1, 2'b11, 1'b1, 3'd2, 16'h7FFF, 1'b0, 1'b0, 1'b0);
        check("neg_7fff", {2'b00, ow[0]}, 4'h0);
        step();
        drive(1'b1, 2'b11, 1'b1, 3'd3, 16'h8000, 1'b0, 1'b0, 1'b0);
        check("ge_8000", {2'b00, ow[0]}, 4'h0);
        step();
        drive(1'b1, 2'b11, 1'b1, 3'd3, 16'h7FFF, 1'b0, 1'b0, 1'b0);
        check("ge_7fff", {2'b00, ow[0]}, 4'h3);
        step();

        // Registered flags: same-cycle evaluation sees the old Z.
        drive(1'b1, 2'b11, 1'b1, 3'd7, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("flags_old_z", {2'b00, ow[0]}, 4'h0);
        step();
        drive(1'b1, 2'b11, 1'b1, 3'd7, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("flags_value", fg[0], 4'b0101);
        check("flags_new_z", {2'b00, ow[0]}, 4'h3);
        step();
        drive(1'b1, 2'b11, 1'b1, 3'd5, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("flags_not_c", {2'b00, ow[0]}, 4'h0);
        step();

        // Drain every flush window.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b11, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
            step();
        end

        // Flush window (2 cycles) and jump during a 3-cycle window.
        drive(1'b1, 2'b11, 1'b1, 3'd0, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("fl2_taken", {3'b000, tk[1]}, 4'h1);
        check("fl3_taken", {3'b000, tk[2]}, 4'h1);
        step();
        drive(1'b1, 2'b11, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 1'b1);
        check("fl2_c1_flush", {3'b000, fl[1]}, 4'h1);
        check("fl2_c1_we", {2'b00, ow[1]}, 4'h0);
        step();
        drive(1'b1, 2'b11, 1'b1, 3'd0, 16'h0001, 1'b1, 1'b1, 1'b1);
        check("fl2_c2_flush", {3'b000, fl[1]}, 4'h1);
        check("fl2_flags_frozen", fg[1], 4'b0000);
        check("fl3_c2_no_retake", {3'b000, tk[2]}, 4'h0);
        step();
        drive(1'b1, 2'b11, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("fl2_c3_flush", {3'b000, fl[1]}, 4'h0);
        check("fl2_c3_we", {2'b00, ow[1]}, 4'h3);
        check("fl3_c3_flush", {3'b000, fl[2]}, 4'h1);
        step();
        drive(1'b1, 2'b11, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("fl3_c4_flush", {3'b000, fl[2]}, 4'h0);
        step();

        // Async reset mid-flush.
        drive(1'b1, 2'b11, 1'b1, 3'd0, 16'h0001, 1'b1, 1'b1, 1'b1);
        step();
        drive(1'b1, 2'b11, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        check("pre_rst_flush", {3'b000, fl[2]}, 4'h1);
        rst_n = 1'b0;
        model_reset();
        drive(1'b0, 2'b00, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("midrst_flush", {3'b000, fl[2]}, 4'h0);
        check("midrst_flags", fg[2], 4'h0);
        step();
        rst_n = 1'b1;
        drive(1'b1, 2'b01, 1'b1, 3'd0, 16'h0001, 1'b0, 1'b0, 1'b0);
        check("post_rst_taken", {3'b000, tk[2]}, 4'h1);
        step();

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
